insn_prefetch_queue: RTL and testbench

//  Fetch-side instruction prefetch buffer between instruction memory (IM) and decode (D0).

---
 rtl/insn_prefetch_queue.sv | 139 +++++++++++++
 tb/tb_insn_prefetch_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_prefetch_queue.sv
// insn_prefetch_queue
// Fetch-side prefetch buffer between instruction memory and decode. Issues
// sequential word reads, queues the returned {pc, insn} pairs, and presents
// the queue head to decode. A resolved branch flushes the queue and redirects
// fetch to the branch target.
// Optional build macro: PFQ_STATS_EN adds the saturating flush_cnt and
// stall_full_cnt statistics outputs.
module insn_prefetch_queue #(
  parameter logic [31:0] base_addr = 32'h80020000,
  parameter int          DEPTH     = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] i_address,
  output logic        i_mem_enable,
  output logic        i_rw,
  output logic [1:0]  i_access_size,
  input  logic        i_busy,
  input  logic [31:0] i_data_in,
  input  logic        stall,
  input  logic        do_branch,
  input  logic [31:0] pc_effective,
  output logic        out_valid,
  output logic [31:0] pc_FD,
  output logic [31:0] insn_FD
`ifdef PFQ_STATS_EN
  ,
  output logic [15:0] flush_cnt,
  output logic [15:0] stall_full_cnt
`endif
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  logic [31:0]     fetchPc_q, fetchPc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflightPc_q, inflightPc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [PtrW-1:0] wrPtr_q, wrPtr_d;

  logic [31:0]     pcMem_q   [DEPTH];
  logic [31:0]     insnMem_q [DEPTH];

  logic            issue;
  logic            push;
  logic            pop;
  logic [CntW:0]   occupancy;

  // Read interface is always a word read.
  assign i_rw          = 1'b1;
  assign i_access_size = 2'b00;
  assign i_address     = fetchPc_q;
  assign i_mem_enable  = issue;

  // Decode sees a NOP bubble with pc 0 whenever the queue is empty.
  assign out_valid = (count_q != '0);
  assign pc_FD     = out_valid ? pcMem_q[rdPtr_q]   : 32'h0;
  assign insn_FD   = out_valid ? insnMem_q[rdPtr_q] : 32'h0;

  // Credit check, queue control and next-state computation. Outstanding reads
  // count against free slots so a returning word always has room. The response
  // in flight during a branch cycle belongs to the old path, so gating the push
  // with do_branch discards it; the branch cycle itself never issues, so no
  // older response can survive past the flush.
  always_comb begin
    occupancy    = {1'b0, count_q} + (CntW+1)'(inflight_q);
    issue        = !reset && !do_branch && !i_busy && (occupancy < (CntW+1)'(DEPTH));
    push         = inflight_q && !do_branch;
    pop          = out_valid && !stall && !do_branch;
    fetchPc_d    = fetchPc_q;
    inflight_d   = issue;
    inflightPc_d = issue ? fetchPc_q : inflightPc_q;
    count_d      = count_q;
    rdPtr_d      = rdPtr_q;
    wrPtr_d      = wrPtr_q;
    if (do_branch) begin
      fetchPc_d = pc_effective;
      count_d   = '0;
      rdPtr_d   = '0;
      wrPtr_d   = '0;
    end else begin
      if (issue) fetchPc_d = fetchPc_q + 32'd4;
      if (push)  wrPtr_d   = wrPtr_q + PtrW'(1);
      if (pop)   rdPtr_d   = rdPtr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Control state register; reset takes priority over branch and stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetchPc_q    <= base_addr;
      inflight_q   <= 1'b0;
      inflightPc_q <= 32'h0;
      count_q      <= '0;
      rdPtr_q      <= '0;
      wrPtr_q      <= '0;
    end else begin
      fetchPc_q    <= fetchPc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
      count_q      <= count_d;
      rdPtr_q      <= rdPtr_d;
      wrPtr_q      <= wrPtr_d;
    end
  end

  // Queue storage; entries are only meaningful while counted, so no reset.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      pcMem_q[wrPtr_q]   <= inflightPc_q;
      insnMem_q[wrPtr_q] <= i_data_in;
    end
  end

`ifdef PFQ_STATS_EN
  logic [15:0] flushCnt_q;
  logic [15:0] stallFullCnt_q;

  assign flush_cnt      = flushCnt_q;
  assign stall_full_cnt = stallFullCnt_q;

  // Saturating counters of redirects and of cycles decode holds a full queue.
  always_ff @(posedge clock) begin
    if (reset) begin
      flushCnt_q     <= 16'h0;
      stallFullCnt_q <= 16'h0;
    end else begin
      if (do_branch && (flushCnt_q != 16'hFFFF))
        flushCnt_q <= flushCnt_q + 16'd1;
      if (stall && (count_q == CntW'(DEPTH)) && (stallFullCnt_q != 16'hFFFF))
        stallFullCnt_q <= stallFullCnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_insn_prefetch_queue.sv
// tb_insn_prefetch_queue
// Directed bench for insn_prefetch_queue with a one-cycle-latency instruction
// memory model whose word at address a is a ^ 32'hA5A55A5A. Build with
// PFQ_STATS_EN defined to also cover the statistics counters.
module tb_insn_prefetch_queue;

  localparam logic [31:0] B = 32'h80020000;

  logic        clock;
  logic        reset;
  logic [31:0] i_address;
  logic        i_mem_enable;
  logic        i_rw;
  logic [1:0]  i_access_size;
  logic        i_busy;
  logic [31:0] i_data_in;
  logic        stall;
  logic        do_branch;
  logic [31:0] pc_effective;
  logic        out_valid;
  logic [31:0] pc_FD;
  logic [31:0] insn_FD;
`ifdef PFQ_STATS_EN
  logic [15:0] flush_cnt;
  logic [15:0] stall_full_cnt;
`endif

  int checks = 0;
  int errors = 0;

  insn_prefetch_queue #(.base_addr(B), .DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_address    (i_address),
    .i_mem_enable (i_mem_enable),
    .i_rw         (i_rw),
    .i_access_size(i_access_size),
    .i_busy       (i_busy),
    .i_data_in    (i_data_in),
    .stall        (stall),
    .do_branch    (do_branch),
    .pc_effective (pc_effective),
    .out_valid    (out_valid),
    .pc_FD        (pc_FD),
    .insn_FD      (insn_FD)
`ifdef PFQ_STATS_EN
    ,
    .flush_cnt     (flush_cnt),
    .stall_full_cnt(stall_full_cnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] insnOf(input logic [31:0] a);
    return a ^ 32'hA5A55A5A;
  endfunction

  // Instruction memory: read data valid the cycle after an issue.
  always @(posedge clock) begin
    if (i_mem_enable) i_data_in <= insnOf(i_address);
    else              i_data_in <= 32'hDEADBEEF;
  end

  task automatic applyStimulus(input logic r, input logic s, input logic b,
                               input logic [31:0] pe, input logic busy);
    reset        = r;
    stall        = s;
    do_branch    = b;
    pc_effective = pe;
    i_busy       = busy;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    i_data_in = 32'h0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_pc", pc_FD, 32'h0);
    checkOutput("rst_insn", insn_FD, 32'h0);
    checkOutput("rst_en", 32'(i_mem_enable), 32'd0);
    checkOutput("rst_addr", i_address, B);
    checkOutput("rw", 32'(i_rw), 32'd1);
    checkOutput("size", 32'(i_access_size), 32'd0);
`ifdef PFQ_STATS_EN
    checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    checkOutput("rst_stall_cnt", 32'(stall_full_cnt), 32'd0);
`endif

    $display("[TB] sequential fetch after reset release");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("c0_en", 32'(i_mem_enable), 32'd1);
    checkOutput("c0_addr", i_address, B);
    tick();
    checkOutput("c1_addr", i_address, B + 32'h4);
    checkOutput("c1_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("c2_valid", 32'(out_valid), 32'd1);
    checkOutput("c2_pc", pc_FD, B);
    checkOutput("c2_insn", insn_FD, insnOf(B));
    checkOutput("c2_addr", i_address, B + 32'h8);
    tick();
    checkOutput("c3_pc", pc_FD, B + 32'h4);

    $display("[TB] stall fills the queue");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("c4_pc", pc_FD, B + 32'h4);
    checkOutput("c4_en", 32'(i_mem_enable), 32'd1);
    checkOutput("c4_addr", i_address, B + 32'h10);
    tick();
    checkOutput("c5_en_credit", 32'(i_mem_enable), 32'd0);
    tick();
    checkOutput("c6_en_full", 32'(i_mem_enable), 32'd0);
    checkOutput("c6_pc", pc_FD, B + 32'h4);
    tick();
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("c9_pc", pc_FD, B + 32'h4);
    checkOutput("c9_en_full", 32'(i_mem_enable), 32'd0);
    tick();
    checkOutput("c10_pc", pc_FD, B + 32'h8);
    checkOutput("c10_en", 32'(i_mem_enable), 32'd1);
    checkOutput("c10_addr", i_address, B + 32'h14);
    tick();
    checkOutput("c11_pc", pc_FD, B + 32'hC);
    tick();
    checkOutput("c12_pc", pc_FD, B + 32'h10);
    tick();
    checkOutput("c13_pc", pc_FD, B + 32'h14);
    checkOutput("c13_insn", insn_FD, insnOf(B + 32'h14));

    $display("[TB] branch with three queued and one inflight");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("c14_pc", pc_FD, B + 32'h14);
    applyStimulus(1'b0, 1'b0, 1'b1, B + 32'h40, 1'b0);
    checkOutput("c14_br_en", 32'(i_mem_enable), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("c15_valid", 32'(out_valid), 32'd0);
    checkOutput("c15_pc", pc_FD, 32'h0);
    checkOutput("c15_insn", insn_FD, 32'h0);
    checkOutput("c15_addr", i_address, B + 32'h40);
    checkOutput("c15_en", 32'(i_mem_enable), 32'd1);
    tick();
    checkOutput("c16_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("c17_pc", pc_FD, B + 32'h40);
    checkOutput("c17_insn", insn_FD, insnOf(B + 32'h40));
    tick();
    checkOutput("c18_pc", pc_FD, B + 32'h44);

    $display("[TB] branch and stall together");
    applyStimulus(1'b0, 1'b1, 1'b1, B + 32'h100, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("bs_valid", 32'(out_valid), 32'd0);
    checkOutput("bs_addr", i_address, B + 32'h100);
    tick();
    tick();
    checkOutput("bs_pc", pc_FD, B + 32'h100);

    $display("[TB] reset and branch together");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h80030000, 1'b0);
    tick();
    checkOutput("rb_addr", i_address, B);
    checkOutput("rb_valid", 32'(out_valid), 32'd0);
    checkOutput("rb_en", 32'(i_mem_enable), 32'd0);
`ifdef PFQ_STATS_EN
    checkOutput("rb_flush_cnt", 32'(flush_cnt), 32'd0);
    checkOutput("rb_stall_cnt", 32'(stall_full_cnt), 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    checkOutput("rb_pc", pc_FD, B);

    $display("[TB] memory busy drains the queue");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("busy_en", 32'(i_mem_enable), 32'd0);
    tick();
    checkOutput("busy_pc", pc_FD, B + 32'h4);
    checkOutput("busy_en2", 32'(i_mem_enable), 32'd0);
    tick();
    checkOutput("busy_empty", 32'(out_valid), 32'd0);
    checkOutput("busy_insn", insn_FD, 32'h0);
    checkOutput("busy_addr", i_address, B + 32'h8);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("resume_en", 32'(i_mem_enable), 32'd1);
    checkOutput("resume_addr", i_address, B + 32'h8);
    checkOutput("resume_valid", 32'(out_valid), 32'd0);
    tick();
    tick();
    checkOutput("resume_pc", pc_FD, B + 32'h8);

    $display("[TB] full-and-stalled cycles then back-to-back branches");
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("full_pc", pc_FD, B + 32'h8);
`ifdef PFQ_STATS_EN
    checkOutput("stall_full_cnt", 32'(stall_full_cnt), 32'd5);
`endif
    applyStimulus(1'b0, 1'b0, 1'b1, B + 32'h200, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, B + 32'h300, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("b2b_addr", i_address, B + 32'h300);
    checkOutput("b2b_valid", 32'(out_valid), 32'd0);
`ifdef PFQ_STATS_EN
    checkOutput("flush_cnt", 32'(flush_cnt), 32'd2);
    checkOutput("stall_full_hold", 32'(stall_full_cnt), 32'd5);
`endif
    tick();
    tick();
    checkOutput("b2b_pc", pc_FD, B + 32'h300);

    $display("[TB] fetch address wraps past 0xFFFFFFFC");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_addr0", i_address, 32'hFFFFFFFC);
    tick();
    checkOutput("wrap_addr1", i_address, 32'h0);
    tick();
    checkOutput("wrap_pc0", pc_FD, 32'hFFFFFFFC);
    tick();
    checkOutput("wrap_valid", 32'(out_valid), 32'd1);
    checkOutput("wrap_pc1", pc_FD, 32'h0);
    checkOutput("wrap_insn1", insn_FD, insnOf(32'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
